// File: rtl/coin_accumulator.sv
// Coin accumulator: turns coin-sensor edges into a running 7-bit credit for the
// vending controller; freezes it during a transaction, clears on consume, refunds on abort/timeout.
module coin_accumulator #(
  parameter int unsigned COIN0_VAL      = 1,
  parameter int unsigned COIN1_VAL      = 2,
  parameter int unsigned COIN2_VAL      = 5,
  parameter int unsigned COIN3_VAL      = 10,
  parameter int unsigned MAX_TOTAL      = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_in,
  input  logic [1:0] coin_type,
  input  logic       lock,
  input  logic       consume,
  input  logic       abort,
  output logic [6:0] coin_total_value,
  output logic       coin_accepted,
  output logic       coin_rejected,
  output logic       refund_valid,
  output logic [6:0] refund_value,
  output logic [1:0] acc_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOCKED  = 2'd2,
    REFUND  = 2'd3
  } state_t;

  function automatic logic [7:0] coin_value(input logic [1:0] t);
    case (t)
      2'b00:   return 8'(COIN0_VAL);
      2'b01:   return 8'(COIN1_VAL);
      2'b10:   return 8'(COIN2_VAL);
      default: return 8'(COIN3_VAL);
    endcase
  endfunction

  function automatic logic fits_ceiling(input logic [7:0] s);
    return (s <= 8'(MAX_TOTAL));
  endfunction

  state_t           state_q, state_d;
  logic [6:0]       total_q, total_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_in_q;
  logic             armed_q, armed_d;
  logic             accepted_q, accepted_d;
  logic             rejected_q, rejected_d;
  logic             refund_valid_q, refund_valid_d;
  logic [6:0]       refund_value_q, refund_value_d;

  logic       coin_edge;
  logic [7:0] sum;
  logic       sum_fits;

  // A rising edge only counts once coin_in has been seen low after reset,
  // so a level held through reset release does not credit a phantom coin.
  assign coin_edge = coin_in & ~coin_in_q & armed_q;
  assign sum       = {1'b0, total_q} + coin_value(coin_type);
  assign sum_fits  = fits_ceiling(sum);

  always_comb begin
    state_d        = state_q;
    total_d        = total_q;
    cnt_d          = cnt_q;
    accepted_d     = 1'b0;
    rejected_d     = 1'b0;
    refund_valid_d = 1'b0;
    refund_value_d = refund_value_q;
    armed_d        = armed_q | ~coin_in;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (coin_edge) begin
          if (sum_fits) begin
            total_d    = sum[6:0];
            accepted_d = 1'b1;
            state_d    = COLLECT;
          end else begin
            rejected_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d        = REFUND;
          refund_valid_d = 1'b1;
          refund_value_d = total_q;
          total_d        = '0;
          rejected_d     = coin_edge;
        end else if (lock) begin
          state_d    = LOCKED;
          rejected_d = coin_edge;
        end else if (coin_edge) begin
          cnt_d = '0;
          if (sum_fits) begin
            total_d    = sum[6:0];
            accepted_d = 1'b1;
          end else begin
            rejected_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d        = REFUND;
          refund_valid_d = 1'b1;
          refund_value_d = total_q;
          total_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        rejected_d = coin_edge;
        if (abort) begin
          state_d        = REFUND;
          refund_valid_d = 1'b1;
          refund_value_d = total_q;
          total_d        = '0;
        end else if (consume) begin
          total_d = '0;
          state_d = IDLE;
        end else if (!lock) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      REFUND: begin
        rejected_d = coin_edge;
        state_d    = IDLE;
        cnt_d      = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      total_q        <= '0;
      cnt_q          <= '0;
      coin_in_q      <= 1'b0;
      armed_q        <= 1'b0;
      accepted_q     <= 1'b0;
      rejected_q     <= 1'b0;
      refund_valid_q <= 1'b0;
      refund_value_q <= '0;
    end else begin
      state_q        <= state_d;
      total_q        <= total_d;
      cnt_q          <= cnt_d;
      coin_in_q      <= coin_in;
      armed_q        <= armed_d;
      accepted_q     <= accepted_d;
      rejected_q     <= rejected_d;
      refund_valid_q <= refund_valid_d;
      refund_value_q <= refund_value_d;
    end
  end

  assign coin_total_value = total_q;
  assign coin_accepted    = accepted_q;
  assign coin_rejected    = rejected_q;
  assign refund_valid     = refund_valid_q;
  assign refund_value     = refund_value_q;
  assign acc_state        = state_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: per-cycle vector table with hand-derived expectations,
// routed through a scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_in;
  logic [1:0] coin_type;
  logic       lock;
  logic       consume;
  logic       abort;
  logic [6:0] coin_total_value;
  logic       coin_accepted;
  logic       coin_rejected;
  logic       refund_valid;
  logic [6:0] refund_value;
  logic [1:0] acc_state;

  always #5 clk = ~clk;

  coin_accumulator #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .coin_in          (coin_in),
    .coin_type        (coin_type),
    .lock             (lock),
    .consume          (consume),
    .abort            (abort),
    .coin_total_value (coin_total_value),
    .coin_accepted    (coin_accepted),
    .coin_rejected    (coin_rejected),
    .refund_valid     (refund_valid),
    .refund_value     (refund_value),
    .acc_state        (acc_state)
  );

  typedef struct {
    logic       ci;
    logic [1:0] ct;
    logic       lk;
    logic       cs;
    logic       ab;
    logic [6:0] tot;
    logic       acc;
    logic       rej;
    logic       rv;
    logic [6:0] rval;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic ci, input logic [1:0] ct, input logic lk, input logic cs,
                     input logic ab, input logic [6:0] tot, input logic acc, input logic rej,
                     input logic rv, input logic [6:0] rval, input logic [1:0] st);
    vec_t v;
    v.ci = ci; v.ct = ct; v.lk = lk; v.cs = cs; v.ab = ab;
    v.tot = tot; v.acc = acc; v.rej = rej; v.rv = rv; v.rval = rval; v.st = st;
    vecs.push_back(v);
  endtask

  // n quiet cycles with coin_in low and no pulses expected
  task automatic gap(input int n, input logic [6:0] tot, input logic [1:0] st,
                     input logic [6:0] rval);
    for (int i = 0; i < n; i++) add(0, 2'd0, 0, 0, 0, tot, 0, 0, 0, rval, st);
  endtask

  // coin edge followed by one low cycle, accepted into COLLECT
  task automatic coin_ok(input logic [1:0] ct, input logic [6:0] tot_after,
                         input logic [6:0] rval);
    add(1, ct, 0, 0, 0, tot_after, 1, 0, 0, rval, 2'd1);
    gap(1, tot_after, 2'd1, rval);
  endtask

  task automatic run_vecs(input string tag);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      coin_in   = vecs[i].ci;
      coin_type = vecs[i].ct;
      lock      = vecs[i].lk;
      consume   = vecs[i].cs;
      abort     = vecs[i].ab;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL %s[%0d]: scoreboard empty, got tot=%0d required an entry", tag, i,
                 coin_total_value);
      end else begin
        e = sb.pop_front();
        if ({coin_total_value, coin_accepted, coin_rejected, refund_valid, refund_value, acc_state}
            !== {e.tot, e.acc, e.rej, e.rv, e.rval, e.st}) begin
          n_bad++;
          $display("FAIL %s[%0d]: got tot=%0d acc=%0b rej=%0b rv=%0b rval=%0d st=%0d, required tot=%0d acc=%0b rej=%0b rv=%0b rval=%0d st=%0d",
                   tag, i, coin_total_value, coin_accepted, coin_rejected, refund_valid,
                   refund_value, acc_state, e.tot, e.acc, e.rej, e.rv, e.rval, e.st);
        end
      end
    end
    vecs.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_total"}, 32'(coin_total_value), 0);
    chk({tag, "_pulses"}, 32'({coin_accepted, coin_rejected, refund_valid}), 0);
    chk({tag, "_refund_value"}, 32'(refund_value), 0);
    chk({tag, "_state"}, 32'(acc_state), 0);
  endtask

  initial begin
    rst = 1'b0; coin_in = 1'b0; coin_type = 2'd0; lock = 1'b0; consume = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b1;

    add(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    // four denominations, one per 4 cycles
    add(1, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd1);  gap(3, 1, 2'd1, 0);
    add(1, 2'd1, 0, 0, 0, 3, 1, 0, 0, 0, 2'd1);  gap(3, 3, 2'd1, 0);
    add(1, 2'd2, 0, 0, 0, 8, 1, 0, 0, 0, 2'd1);  gap(3, 8, 2'd1, 0);
    add(1, 2'd3, 0, 0, 0, 18, 1, 0, 0, 0, 2'd1); gap(1, 18, 2'd1, 0);
    add(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 18, 2'd3); gap(1, 0, 2'd0, 18);
    // fill to the ceiling, then overflow attempts
    for (int k = 1; k <= 10; k++) coin_ok(2'd3, 7'(10 * k), 18);
    add(1, 2'd3, 0, 0, 0, 100, 0, 1, 0, 18, 2'd1); gap(1, 100, 2'd1, 18);
    add(1, 2'd0, 0, 0, 0, 100, 0, 1, 0, 18, 2'd1); gap(1, 100, 2'd1, 18);
    add(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 100, 2'd3); gap(1, 0, 2'd0, 100);
    // lock, coin while locked, consume
    for (int k = 1; k <= 5; k++) coin_ok(2'd3, 7'(10 * k), 100);
    add(0, 2'd0, 1, 0, 0, 50, 0, 0, 0, 100, 2'd2);
    add(1, 2'd2, 1, 0, 0, 50, 0, 1, 0, 100, 2'd2);
    add(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 100, 2'd0);
    gap(1, 0, 2'd0, 100);
    // abort with simultaneous coin
    coin_ok(2'd3, 10, 100); coin_ok(2'd3, 20, 100); coin_ok(2'd2, 25, 100);
    add(1, 2'd2, 0, 0, 1, 0, 0, 1, 1, 25, 2'd3);
    gap(1, 0, 2'd0, 25);
    // coin on lock rise, unlock, then abort beats consume
    coin_ok(2'd3, 10, 25);
    add(1, 2'd0, 1, 0, 0, 10, 0, 1, 0, 25, 2'd2);
    add(0, 2'd0, 0, 0, 0, 10, 0, 0, 0, 25, 2'd1);
    add(0, 2'd0, 1, 0, 0, 10, 0, 0, 0, 25, 2'd2);
    add(0, 2'd0, 1, 1, 1, 0, 0, 0, 1, 10, 2'd3);
    gap(1, 0, 2'd0, 10);
    // inactivity timeout after 8 COLLECT cycles
    add(1, 2'd1, 0, 0, 0, 2, 1, 0, 0, 10, 2'd1);
    gap(7, 2, 2'd1, 10);
    add(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2, 2'd3);
    gap(1, 0, 2'd0, 2);
    // coin on the timeout cycle is accepted and no refund follows
    add(1, 2'd1, 0, 0, 0, 2, 1, 0, 0, 2, 2'd1);
    gap(7, 2, 2'd1, 2);
    add(1, 2'd1, 0, 0, 0, 4, 1, 0, 0, 2, 2'd1);
    gap(3, 4, 2'd1, 2);
    add(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 4, 2'd3);
    gap(1, 0, 2'd0, 4);
    // build 30 and lock, coin_in rises and stays high
    coin_ok(2'd3, 10, 4); coin_ok(2'd3, 20, 4); coin_ok(2'd3, 30, 4);
    add(0, 2'd0, 1, 0, 0, 30, 0, 0, 0, 4, 2'd2);
    add(1, 2'd0, 1, 0, 0, 30, 0, 1, 0, 4, 2'd2);
    run_vecs("main");

    // asynchronous reset mid-cycle while LOCKED with coin_in held high
    #3;
    rst = 1'b0;
    #1;
    chk_cleared("async_reset");
    @(posedge clk);
    #1;
    chk_cleared("reset_held");
    lock = 1'b0;
    rst  = 1'b1;

    add(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    add(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    add(1, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    add(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    add(1, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd1);
    add(1, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd1);
    add(1, 2'd0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd1);
    gap(1, 1, 2'd1, 0);
    add(1, 2'd1, 0, 0, 0, 3, 1, 0, 0, 0, 2'd1);
    gap(1, 3, 2'd1, 0);
    run_vecs("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
- Front-end stage directly upstream of the vending machine controller.
- Converts discrete coin-sensor events into the 7-bit running credit that drives the controller's coin_total_value input.
- Freezes the credit while the controller runs a transaction, clears it when the controller consumes it, and refunds it on abort or inactivity timeout.

Parameters:
- COIN0_VAL, 1, value credited for coin_type 2'b00
- COIN1_VAL, 2, value credited for coin_type 2'b01
- COIN2_VAL, 5, value credited for coin_type 2'b10
- COIN3_VAL, 10, value credited for coin_type 2'b11
- MAX_TOTAL, 100, credit ceiling (must be ≤127)
- TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-refund (≥2)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- coin_in  in  1  coin sensor level; one coin per rising edge
- coin_type  in  2  denomination, sampled in the coin_in rising-edge cycle
- lock  in  1  controller transaction in progress (driven from initiate)
- consume  in  1  one-cycle pulse from controller on dispense
- abort  in  1  cancel request
- coin_total_value  out  7  current credit to controller
- coin_accepted  out  1  one-cycle pulse, coin credited
- coin_rejected  out  1  one-cycle pulse, coin refused (returned mechanically)
- refund_valid  out  1  one-cycle pulse, credit being refunded
- refund_value  out  7  refunded amount, valid with refund_valid
- acc_state  out  2  IDLE=0, COLLECT=1, LOCKED=2, REFUND=3

Behaviour:
- Reset (rst=0, async):
  - coin_total_value=0, refund_value=0, all pulses 0, acc_state=IDLE.
  - Timeout counter=0; coin_in edge register=0.
  - Reset mid-transaction discards stored credit without a refund pulse.
- Edge detect:
  - Edge = coin_in & ~coin_in_q, where coin_in_q is a registered copy.
  - A held-high coin_in counts once.
  - Edge detected in cycle t; all effects appear registered at t+1.
- Coin accept, IDLE or COLLECT only:
  - sum = total + COINx_VAL computed at 8 bits.
  - If sum ≤ MAX_TOTAL: total=sum and coin_accepted=1 at t+1. IDLE→COLLECT. Timeout counter cleared.
  - If sum > MAX_TOTAL: coin_rejected=1 at t+1; total unchanged. Exactly reaching MAX_TOTAL is accepted.
- LOCKED/REFUND: every coin edge → coin_rejected pulse; total unchanged.
- FSM transitions, evaluated each cycle, priority abort > consume > lock > coin edge > timeout:
  - IDLE:
    - Accepted coin → COLLECT.
    - abort, consume and lock are ignored (no pulses).
  - COLLECT:
    - abort → REFUND.
    - lock=1 → LOCKED.
    - Counter reaching TIMEOUT_CYCLES-1 with no edge → REFUND.
    - Otherwise the counter increments.
  - LOCKED:
    - Counter frozen.
    - abort → REFUND.
    - consume → total=0, IDLE (no refund pulse; change is returned by the controller).
    - lock=0 without consume → COLLECT, counter cleared.
  - REFUND:
    - Entered at cycle t+1 with refund_valid=1, refund_value=pre-refund total, coin_total_value=0 in that same cycle.
    - Next cycle → IDLE, refund_valid=0.
    - refund_value holds until the next refund.
- Simultaneous events:
  - Coin edge with abort: the coin is rejected and only the prior total is refunded.
  - consume with abort in LOCKED: abort wins (refund).
  - Coin edge in the cycle COLLECT→LOCKED (lock rising): the coin is rejected.
  - Coin edge on the timeout cycle: the coin is accepted and the counter is cleared, so no refund occurs.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then coin_type=00,01,10,11 edges, one per 4 cycles → coin_accepted ×4, total 1,3,8,18, acc_state IDLE→COLLECT.
- Ten 10-coin edges → total 100 after tenth. Eleventh 10-coin → coin_rejected, total stays 100. Then a 1-coin → rejected.
- Total 50, lock=1 → LOCKED. Coin edge → rejected, total 50. consume pulse → total 0, acc_state IDLE, no refund_valid.
- Total 25 in COLLECT, abort with simultaneous 5-coin edge → next cycle refund_valid=1, refund_value=25, total 0, coin_rejected=1. Following cycle IDLE.
- TIMEOUT_CYCLES=8, insert a 2-coin then idle → refund_valid with refund_value=2 after 8 COLLECT cycles. Repeat with a coin at cycle 7 → no refund, total 4.
- Total 30 in LOCKED, drop rst to 0 mid-cycle → outputs 0 immediately (async), acc_state IDLE, no refund pulse. coin_in held high through reset release → no credit until a new rising edge.
